// File: rtl/branch_resolve_stage.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_stage
// Purpose  : Registers ALU results, resolves conditional branches into a
//            one-cycle fetch redirect and squashes the wrong-path shadow.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_stage #(
  parameter int SHADOW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pc,
  input  logic [63:0] in_imm,
  input  logic        in_is_branch,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_alu_result,
  input  logic        in_equal,
  input  logic        in_not_equal,
  input  logic        in_lesser_than,
  input  logic        in_greater_or_equal,
  input  logic        in_unsigned_lesser,
  input  logic        in_unsigned_greater_equal,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_is_branch,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        illegal_branch
);

  localparam logic [2:0] c_SHADOW = 3'(SHADOW);

  logic        r_out_valid;
  logic [63:0] r_out_result;
  logic [4:0]  r_out_rd;
  logic        r_out_reg_write;
  logic        r_out_is_branch;
  logic        r_redirect_valid;
  logic [63:0] r_redirect_pc;
  logic        r_illegal;
  logic [2:0]  r_cnt;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_squashing;
  logic        w_cond;
  logic        w_bad_funct3;
  logic        w_forward;
  logic        w_taken;
  logic [63:0] w_target;

  assign w_in_ready   = !r_out_valid || out_ready;
  assign w_accept     = in_valid && w_in_ready;
  assign w_squashing  = (r_cnt != 3'd0);
  assign w_forward    = w_accept && !w_squashing;
  assign w_bad_funct3 = (in_funct3[2:1] == 2'b01);
  assign w_taken      = w_forward && in_is_branch && w_cond;
  assign w_target     = in_pc + in_imm;

  always_comb begin
    w_cond = 1'b0;
    case (in_funct3)
      3'b000:  w_cond = in_equal;
      3'b001:  w_cond = in_not_equal;
      3'b100:  w_cond = in_lesser_than;
      3'b101:  w_cond = in_greater_or_equal;
      3'b110:  w_cond = in_unsigned_lesser;
      3'b111:  w_cond = in_unsigned_greater_equal;
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid      <= 1'b0;
      r_out_result     <= 64'd0;
      r_out_rd         <= 5'd0;
      r_out_reg_write  <= 1'b0;
      r_out_is_branch  <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 64'd0;
      r_illegal        <= 1'b0;
      r_cnt            <= 3'd0;
    end else begin
      if (w_forward) begin
        r_out_valid     <= 1'b1;
        r_out_result    <= in_alu_result;
        r_out_rd        <= in_rd;
        r_out_reg_write <= in_reg_write && !in_is_branch;
        r_out_is_branch <= in_is_branch;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      // Only transfers that actually handshake advance the shadow count.
      if (w_accept) begin
        if (w_squashing) begin
          r_cnt <= r_cnt - 3'd1;
        end else if (w_taken) begin
          r_cnt <= c_SHADOW;
        end
      end

      r_redirect_valid <= w_taken;
      r_redirect_pc    <= w_taken ? w_target : 64'd0;

      if (w_forward && in_is_branch && w_bad_funct3) begin
        r_illegal <= 1'b1;
      end
    end
  end

  assign in_ready       = w_in_ready;
  assign out_valid      = r_out_valid;
  assign out_result     = r_out_result;
  assign out_rd         = r_out_rd;
  assign out_reg_write  = r_out_reg_write;
  assign out_is_branch  = r_out_is_branch;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign illegal_branch = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_stage
// Purpose  : Directed plus randomized bench with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_stage;

  localparam int SHADOW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0;
  logic [63:0] in_imm = '0;
  logic        in_is_branch = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [63:0] in_alu_result;
  logic        in_equal, in_not_equal, in_lesser_than, in_greater_or_equal;
  logic        in_unsigned_lesser, in_unsigned_greater_equal;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_is_branch;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        illegal_branch;

  // ALU operands; the flags below play the role of the upstream ALU.
  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;

  assign in_alu_result             = op_a - op_b;
  assign in_equal                  = (op_a == op_b);
  assign in_not_equal              = (op_a != op_b);
  assign in_lesser_than            = ($signed(op_a) < $signed(op_b));
  assign in_greater_or_equal       = ($signed(op_a) >= $signed(op_b));
  assign in_unsigned_lesser        = (op_a < op_b);
  assign in_unsigned_greater_equal = (op_a >= op_b);

  always #5 clk = ~clk;

  branch_resolve_stage #(.SHADOW(SHADOW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_is_branch(in_is_branch), .in_funct3(in_funct3),
    .in_alu_result(in_alu_result),
    .in_equal(in_equal), .in_not_equal(in_not_equal),
    .in_lesser_than(in_lesser_than), .in_greater_or_equal(in_greater_or_equal),
    .in_unsigned_lesser(in_unsigned_lesser),
    .in_unsigned_greater_equal(in_unsigned_greater_equal),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_is_branch(out_is_branch),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .illegal_branch(illegal_branch)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: what the stage should show after the next edge.
  int          m_shadow_left;
  logic        m_ov;
  logic [63:0] m_res;
  logic [4:0]  m_rd;
  logic        m_rw;
  logic        m_br;
  logic        m_rv;
  logic [63:0] m_rpc;
  logic        m_ill;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic branch_cond(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_shadow_left = 0;
    m_ov = 0; m_res = '0; m_rd = '0; m_rw = 0; m_br = 0;
    m_rv = 0; m_rpc = '0; m_ill = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_out_result"}, out_result, 64'd0);
    chk({tag, "_out_rd"}, {59'd0, out_rd}, 64'd0);
    chk({tag, "_out_reg_write"}, {63'd0, out_reg_write}, 64'd0);
    chk({tag, "_out_is_branch"}, {63'd0, out_is_branch}, 64'd0);
    chk({tag, "_redirect_valid"}, {63'd0, redirect_valid}, 64'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 64'd0);
    chk({tag, "_illegal"}, {63'd0, illegal_branch}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  // One clock: check in_ready, advance the model, then check registered outputs.
  task automatic tick();
    logic rdy, acc, tk;
    @(negedge clk);
    rdy = !m_ov || out_ready;
    acc = in_valid && rdy;
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    m_rv = 0;
    if (acc && m_shadow_left > 0) begin
      m_shadow_left--;
      m_ov = m_ov && !out_ready;
    end else if (acc) begin
      m_ov  = 1;
      m_res = op_a - op_b;
      m_rd  = in_rd;
      m_br  = in_is_branch;
      m_rw  = in_is_branch ? 1'b0 : in_reg_write;
      tk = in_is_branch && branch_cond(in_funct3, op_a, op_b);
      if (tk) begin
        m_rv = 1;
        m_rpc = in_pc + in_imm;
        m_shadow_left = SHADOW;
      end
      if (in_is_branch && (in_funct3 == 3'b010 || in_funct3 == 3'b011)) m_ill = 1;
    end else begin
      m_ov = m_ov && !out_ready;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
    if (m_ov) begin
      chk("out_result", out_result, m_res);
      chk("out_rd", {59'd0, out_rd}, {59'd0, m_rd});
      chk("out_reg_write", {63'd0, out_reg_write}, {63'd0, m_rw});
      chk("out_is_branch", {63'd0, out_is_branch}, {63'd0, m_br});
    end
    chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, m_rv});
    if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    chk("illegal_branch", {63'd0, illegal_branch}, {63'd0, m_ill});
  endtask

  task automatic alu_op(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    in_valid = 1; in_is_branch = 0; in_funct3 = 3'b000;
    op_a = a; op_b = b; in_rd = rd; in_reg_write = 1;
    in_pc = 64'h2000; in_imm = 64'h0;
  endtask

  task automatic branch_op(input logic [2:0] f3, input logic [63:0] pc, input logic [63:0] imm,
                           input logic [63:0] a, input logic [63:0] b);
    in_valid = 1; in_is_branch = 1; in_funct3 = f3;
    op_a = a; op_b = b; in_rd = 5'd0; in_reg_write = 1;
    in_pc = pc; in_imm = imm;
  endtask

  task automatic idle();
    in_valid = 0;
  endtask

  initial begin
    m_reset();
    rst_n = 0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Plain ALU op.
    out_ready = 1;
    alu_op(64'h2A, 64'h0, 5'd5);
    tick();
    chk("alu_result_2a", out_result, 64'h2A);
    chk("alu_rd5", {59'd0, out_rd}, 64'd5);

    // Taken BEQ followed by three ALU ops: two dropped, third forwarded.
    branch_op(3'b000, 64'h1000, 64'h40, 64'd7, 64'd7);
    tick();
    chk("beq_redirect_pc", redirect_pc, 64'h1040);
    chk("beq_reg_write0", {63'd0, out_reg_write}, 64'd0);
    alu_op(64'd11, 64'd1, 5'd1); tick();
    chk("beq_pulse_one_cycle", {63'd0, redirect_valid}, 64'd0);
    alu_op(64'd12, 64'd1, 5'd2); tick();
    alu_op(64'd13, 64'd1, 5'd3); tick();
    chk("beq_third_forwarded_rd", {59'd0, out_rd}, 64'd3);
    idle(); tick();

    // BLTU not taken, then an op that must be forwarded.
    branch_op(3'b110, 64'h3000, 64'h80, 64'd5, 64'd3); tick();
    alu_op(64'd20, 64'd0, 5'd7); tick();
    chk("bltu_nt_next_fwd", {63'd0, out_valid}, 64'd1);

    // BGE taken with target wrap-around; idle cycles do not consume shadow.
    branch_op(3'b101, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'd3, 64'd1); tick();
    chk("bge_wrap_pc", redirect_pc, 64'h10);
    idle(); tick(); tick();
    alu_op(64'd30, 64'd0, 5'd8); tick();
    alu_op(64'd31, 64'd0, 5'd9); tick();
    alu_op(64'd32, 64'd0, 5'd10); tick();
    chk("bge_after_shadow_rd", {59'd0, out_rd}, 64'd10);

    // Downstream stall for four cycles with a new op waiting.
    alu_op(64'hAA, 64'd0, 5'd11); tick();
    out_ready = 0;
    alu_op(64'hBB, 64'd0, 5'd12);
    repeat (4) begin
      tick();
      chk("stall_hold_result", out_result, 64'hAA);
    end
    out_ready = 1;
    tick();
    chk("stall_release_result", out_result, 64'hBB);
    idle(); tick();

    // Illegal funct3 sets a sticky flag without redirecting.
    branch_op(3'b010, 64'h4000, 64'h10, 64'd1, 64'd1); tick();
    chk("illegal_set", {63'd0, illegal_branch}, 64'd1);
    idle(); tick(); tick();
    branch_op(3'b011, 64'h4000, 64'h10, 64'd1, 64'd1); tick();

    // Asynchronous reset in the middle of a squash window.
    branch_op(3'b001, 64'h5000, 64'h8, 64'd1, 64'd2); tick();
    alu_op(64'd40, 64'd0, 5'd13); tick();
    idle();
    #2;
    rst_n = 0;
    #1;
    chk_all_zero("midsquash_reset");
    m_reset();
    @(negedge clk);
    rst_n = 1;
    alu_op(64'd41, 64'd0, 5'd14); tick();
    chk("post_reset_forward", {63'd0, out_valid}, 64'd1);

    // Randomized traffic with backpressure.
    for (int i = 0; i < 600; i++) begin
      in_valid     = ($urandom_range(0, 9) < 7);
      out_ready    = ($urandom_range(0, 3) != 0);
      in_is_branch = ($urandom_range(0, 9) < 4);
      in_funct3    = 3'($urandom_range(0, 7));
      op_a         = {$urandom, $urandom};
      op_b         = ($urandom_range(0, 3) == 0) ? op_a : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) op_b = ~op_a;
      in_pc        = {$urandom, $urandom};
      in_imm       = {$urandom, $urandom};
      in_rd        = 5'($urandom_range(0, 31));
      in_reg_write = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_resolve_stage.md
# branch_resolve_stage

Execute-stage back end of the RISC-V datapath: it sits directly downstream of the ALU, registering the ALU result and converting the ALU comparison flags into a branch decision. It forwards non-squashed instructions to the memory stage over a valid/ready handshake. On a taken branch it issues a one-cycle redirect to fetch and discards the wrong-path instructions already in flight behind the branch.

## Interface
Parameters:
- SHADOW, 2: number of accepted transfers squashed after a taken branch (1..7).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  64  PC of the instruction.
- in_imm  in  64  sign-extended branch offset.
- in_is_branch  in  1  instruction is a conditional branch.
- in_funct3  in  3  branch condition select.
- in_alu_result  in  64  ALU result (A−B for branches).
- in_equal, in_not_equal, in_lesser_than, in_greater_or_equal, in_unsigned_lesser, in_unsigned_greater_equal  in  1 each  ALU comparison flags.
- in_rd  in  5  destination register.
- in_reg_write  in  1  write-enable request.
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  memory stage accepts.
- out_result  out  64  registered ALU result.
- out_rd  out  5  registered destination.
- out_reg_write  out  1  registered write enable; forced to 0 for branches.
- out_is_branch  out  1  registered branch marker.
- redirect_valid  out  1  one-cycle pulse on a taken branch.
- redirect_pc  out  64  branch target; valid only while redirect_valid is high.
- illegal_branch  out  1  sticky error; set by a branch whose funct3 is 010 or 011.

## Operation
- Accept = in_valid && in_ready, where in_ready = !out_valid || out_ready. There is no internal buffering beyond the output register.
- Condition map (in_funct3 → flag):
  - 000 → equal
  - 001 → not_equal
  - 100 → lesser_than
  - 101 → greater_or_equal
  - 110 → unsigned_lesser
  - 111 → unsigned_greater_equal
  - 010/011 → not taken, and sets illegal_branch.
- taken = accept && in_is_branch && condition && !squashing.
- Target = in_pc + in_imm, computed modulo 2^64; carry out is discarded, so wrap-around is legal.
- Squash counter (3 bits), states:
  - IDLE (cnt=0): every accepted transfer is forwarded. A taken branch loads cnt=SHADOW.
  - SQUASH (cnt>0): each accepted transfer is dropped (out_valid is not set for it) and cnt decrements. A dropped branch never redirects and never sets illegal_branch. Reaching cnt=0 returns to IDLE.
  - Cycles without an accepted transfer leave cnt unchanged.
- A branch instruction is itself forwarded with out_reg_write=0 and out_is_branch=1.
- Output register:
  - Loads on accept of a non-squashed instruction.
  - Otherwise out_valid clears when out_ready is high.
  - Holds while out_valid && !out_ready; data is stable under stall.
- illegal_branch stays set until reset.

## Timing
- Latency: 1 cycle from accept to out_valid.
- redirect_valid and redirect_pc are registered and assert the cycle after the taken branch is accepted, concurrent with the branch's out_valid. The pulse lasts exactly one cycle, independent of out_ready.
- A downstream stall blocks accept, so no transfer is counted against SHADOW while stalled.
- Simultaneous events:
  - A taken branch in the same cycle as the final squash decrement is itself squashed.
  - Back-to-back accepts flow at full throughput when out_ready=1.
- Reset (asynchronous, any time, including mid-squash) clears out_valid, out_result, out_rd, out_reg_write, out_is_branch, redirect_valid, redirect_pc, illegal_branch and cnt. in_ready is 1 during and immediately after reset.

## Test plan
- Non-branch ALU op, result 0x0000_0000_0000_002A, rd=5, reg_write=1, out_ready=1 → next cycle out_valid=1, out_result=0x2A, out_rd=5, out_reg_write=1, redirect_valid=0.
- BEQ (funct3=000, equal=1), pc=0x1000, imm=0x40, followed by 3 back-to-back ALU ops → one redirect pulse with redirect_pc=0x1040; branch forwarded with reg_write=0; next 2 ops dropped; 3rd op forwarded.
- BLTU not taken (unsigned_lesser=0) → no redirect, cnt stays 0; BGE taken with pc=0xFFFF_FFFF_FFFF_FFF0, imm=0x20 → redirect_pc=0x10 (wrap-around).
- Hold out_ready=0 for 4 cycles with out_valid=1 → in_ready=0, outputs stable; input presented during the stall is accepted only after out_ready rises, one cycle later.
- Branch with funct3=010 → illegal_branch=1, no redirect, flag persists; assert rst_n=0 mid-squash (cnt=1) → all outputs 0, cnt=0, next instruction is forwarded.
